// File: rtl/fp_mul_arbiter.sv
// Round-robin front end sharing one FP multiplier among NUM_REQ requesters.
// Ports: clk/rst, enable, req_* (valid/ready/operands per requester),
//   mul_* (issue to and results from the multiplier), rsp_* (steered
//   response), fflags/fflags_clear (sticky flags), outstanding, seq_error.
module fp_mul_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*32-1:0]                req_in1,
    input  logic [NUM_REQ*32-1:0]                req_in2,
    input  logic [NUM_REQ*3-1:0]                 req_rounding_mode,
    output logic                                 mul_valid_data_in,
    output logic [31:0]                          mul_in1,
    output logic [31:0]                          mul_in2,
    output logic [2:0]                           mul_rounding_mode,
    input  logic [31:0]                          mul_out,
    input  logic                                 mul_overflow,
    input  logic                                 mul_underflow,
    input  logic                                 mul_inexact,
    input  logic                                 mul_invalid_operation,
    input  logic                                 mul_valid_data_out,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [31:0]                          rsp_data,
    output logic [3:0]                           rsp_flags,
    output logic [NUM_REQ*4-1:0]                 fflags,
    input  logic [NUM_REQ-1:0]                   fflags_clear,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 seq_error
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] head;
    logic [ID_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            can_grant;
    logic            any_gnt;
    logic            push;
    logic            pop;
    logic [3:0]      new_flags;

    assign new_flags = {mul_invalid_operation, mul_overflow,
                        mul_underflow, mul_inexact};
    assign head = tag_mem[rd_ptr];
    assign pop  = mul_valid_data_out && (outstanding != '0);
    assign push = any_gnt;

    // A result popping this cycle frees a slot, so a full FIFO may still grant.
    always_comb begin
        can_grant = !rst && enable &&
                    ((outstanding != FULL) || mul_valid_data_out);
        any_gnt   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (can_grant && !any_gnt &&
                req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                any_gnt = 1'b1;
                gnt_id  = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
        if (any_gnt) req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr               <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            outstanding       <= '0;
            mul_valid_data_in <= 1'b0;
            mul_in1           <= '0;
            mul_in2           <= '0;
            mul_rounding_mode <= '0;
            rsp_valid         <= '0;
            rsp_data          <= '0;
            rsp_flags         <= '0;
            fflags            <= '0;
            seq_error         <= 1'b0;
        end else begin
            mul_valid_data_in <= push;
            if (push) begin
                mul_in1           <= req_in1[int'(gnt_id)*32 +: 32];
                mul_in2           <= req_in2[int'(gnt_id)*32 +: 32];
                mul_rounding_mode <= req_rounding_mode[int'(gnt_id)*3 +: 3];
                wr_ptr            <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                ptr               <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[head] <= 1'b1;
                rsp_data        <= mul_out;
                rsp_flags       <= new_flags;
            end
            // Clear applies first so a same-cycle set survives.
            for (int i = 0; i < NUM_REQ; i++) begin
                fflags[i*4 +: 4] <= (fflags_clear[i] ? 4'b0 : fflags[i*4 +: 4]) |
                                    ((pop && head == ID_W'(i)) ? new_flags : 4'b0);
            end
            if (mul_valid_data_out && outstanding == '0) seq_error <= 1'b1;
        end
    end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Shares one fp_multiply_pipeline instance among NUM_REQ independent requesters, such as the scalar FPU issue port and a vector lane.
- Arbitrates requests round-robin and registers the selected operands into the multiplier.
- Tracks the requester ID of every in-flight operation in an in-order tag FIFO.
- Steers each result and its exception flags back to the originating requester.
- Keeps per-requester sticky exception flags, in fflags style.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
MAX_OUTSTANDING, 8, tag FIFO depth, i.e. the maximum number of operations in flight in the multiplier (≥ multiplier latency + 1 for full throughput).
ID_W, $clog2(NUM_REQ), tag width.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
enable  in  1  when 0, no new grants are issued; in-flight operations still complete.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester grant (one-hot or zero).
req_in1  in  NUM_REQ*32  operand A; slice i belongs to requester i.
req_in2  in  NUM_REQ*32  operand B.
req_rounding_mode  in  NUM_REQ*3  rounding mode.
mul_valid_data_in  out  1  issue strobe to the multiplier.
mul_in1, mul_in2  out  32 each  issued operands.
mul_rounding_mode  out  3  issued rounding mode.
mul_out  in  32  multiplier result.
mul_overflow, mul_underflow, mul_inexact, mul_invalid_operation  in  1 each  multiplier flags.
mul_valid_data_out  in  1  result strobe from the multiplier.
rsp_valid  out  NUM_REQ  one-hot response strobe.
rsp_data  out  32  result, shared by all requesters.
rsp_flags  out  4  {invalid, overflow, underflow, inexact} for this result.
fflags  out  NUM_REQ*4  sticky flags, same bit order as rsp_flags, slice i belongs to requester i.
fflags_clear  in  NUM_REQ  per-requester sticky clear.
outstanding  out  $clog2(MAX_OUTSTANDING+1)  number of operations in flight.
seq_error  out  1  sticky flag: a result arrived with no tag in the FIFO.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - all outputs go to 0, including req_ready, rsp_valid, fflags, outstanding and seq_error;
  - the round-robin pointer goes to 0;
  - the tag FIFO is emptied;
  - results returning after reset are ignored (not flagged), because the multiplier is reset by the same rst.
- Grant (combinational):
  - condition: enable=1 and outstanding < MAX_OUTSTANDING, or outstanding == MAX_OUTSTANDING with mul_valid_data_out=1 in the same cycle (pop frees a slot);
  - req_ready is one-hot on the first requester with req_valid=1, searching from the pointer upward and wrapping at NUM_REQ;
  - req_ready never asserts for a requester whose req_valid=0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - At that clock edge: mul_in1/mul_in2/mul_rounding_mode take slice i, mul_valid_data_in=1, tag i is pushed into the FIFO, and the pointer moves to (i+1) mod NUM_REQ.
  - With no transfer: mul_valid_data_in=0, the pointer holds, and the mul_* operands hold their last values.
- Issue latency: 1 cycle from handshake to mul_valid_data_in. Throughput is 1 operation per cycle.
- Return path: on mul_valid_data_out=1 with the FIFO non-empty:
  - pop the head tag t;
  - the next cycle, rsp_valid = onehot(t), rsp_data = mul_out and rsp_flags = the 4 flags (registered, 1 cycle);
  - rsp_valid is 0 otherwise and rsp_data holds its value.
- Responses have no backpressure; requesters must accept them. Results return strictly in issue order.
- Sticky flags: fflags[t] next = (fflags_clear[t] ? 0 : fflags[t]) | new flags. A set in the same cycle as a clear wins. Clearing with no response simply zeroes the slice.
- Counter: outstanding increments on push and decrements on pop. A simultaneous push and pop leaves it unchanged. It never wraps.
- Error case: mul_valid_data_out=1 with the FIFO empty → seq_error is set (sticky until rst), the response is dropped and no counter underflow occurs.
- enable deasserted mid-stream: in-flight operations drain normally and outstanding reaches 0.

Test Plan:
- Single request: requester 2 sends 0x3FC00000 × 0x40000000 (RNE); the model returns 0x40400000 after N cycles → rsp_valid=0b0100, rsp_data=0x40400000, rsp_flags=0, outstanding goes 0→1→0.
- All 4 requesters valid continuously → grants 0,1,2,3,0,… one per cycle; each response reaches its own requester in order with no gaps.
- MAX_OUTSTANDING=2 with a model latency of 5 → at most 2 issues; req_ready drops while full; a pop and push in the same cycle keeps outstanding=2.
- Requester 1 sends 0x7F800000 × 0x00000000 → rsp_flags=1000 and fflags[1]=1000. Then fflags_clear[1] asserts in the same cycle as an inexact response to requester 1 → fflags[1]=0001.
- Model injects mul_valid_data_out with the FIFO empty → seq_error=1, no rsp_valid, outstanding stays 0.
- rst asserted with 3 operations in flight → next cycle all outputs are 0, the pointer is 0 and the FIFO is empty.
